// File: rtl/ps_grant_hold.sv
// ps_grant_hold: locks a one-hot selector grant into registered ownership until
// done, request drop or hold limit, with a one-cycle cool-down gap between owners.
module ps_grant_hold #(
   parameter int MAX_HOLD = 8
) (
   input  logic       i_clock,
   input  logic       i_reset_n,
   input  logic [3:0] i_req,
   input  logic [3:0] i_sel_gnt,
   input  logic       i_sel_req_up,
   input  logic       i_done,
   output logic       o_sel_en,
   output logic [3:0] o_gnt,
   output logic       o_busy,
   output logic       o_timeout,
   output logic       o_err
);
   localparam int CNT_W = $clog2(MAX_HOLD + 1);
   typedef enum logic [1:0] {S_IDLE, S_OWN, S_COOL} state_t;
   state_t           r_state, w_state_nxt;
   logic [3:0]       r_gnt, w_gnt_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_timeout, w_timeout_nxt;
   logic             r_err, w_err_nxt;
   logic             w_onehot, w_rel;
   assign w_onehot = (i_sel_gnt != 4'd0) && ((i_sel_gnt & (i_sel_gnt - 4'd1)) == 4'd0);
   assign w_rel    = i_done | ~|(i_req & r_gnt);
   always_comb begin
      w_state_nxt   = r_state;
      w_gnt_nxt     = r_gnt;
      w_cnt_nxt     = r_cnt;
      w_timeout_nxt = 1'b0;
      w_err_nxt     = r_err;
      case (r_state)
         S_IDLE: begin
            if (i_sel_req_up && w_onehot) begin
               w_gnt_nxt   = i_sel_gnt;
               w_cnt_nxt   = CNT_W'(1);
               w_state_nxt = S_OWN;
            end else if (i_sel_req_up) begin
               w_err_nxt = 1'b1;
            end
         end
         S_OWN: begin
            // release by the owner wins over the hold limit
            if (w_rel) begin
               w_gnt_nxt   = 4'd0;
               w_state_nxt = S_COOL;
            end else if (r_cnt == CNT_W'(MAX_HOLD)) begin
               w_gnt_nxt     = 4'd0;
               w_timeout_nxt = 1'b1;
               w_state_nxt   = S_COOL;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_COOL: begin
            w_gnt_nxt   = 4'd0;
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_gnt_nxt   = 4'd0;
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state   <= S_IDLE;
         r_gnt     <= 4'd0;
         r_cnt     <= '0;
         r_timeout <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_gnt     <= w_gnt_nxt;
         r_cnt     <= w_cnt_nxt;
         r_timeout <= w_timeout_nxt;
         r_err     <= w_err_nxt;
      end
   end
   assign o_sel_en  = (r_state == S_IDLE);
   assign o_gnt     = r_gnt;
   assign o_busy    = (r_state == S_OWN);
   assign o_timeout = r_timeout;
   assign o_err     = r_err;
endmodule

// File: tb/tb_ps_grant_hold.sv
// tb_ps_grant_hold: directed checks of ownership locking, release, timeout,
// cool-down gap, error flag and asynchronous reset.
module tb_ps_grant_hold;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req, sel_gnt;
   logic       sel_req_up, done;
   logic       sel_en, busy, timeout, err;
   logic [3:0] gnt;
   int         n_tests = 0;
   int         n_fail = 0;

   ps_grant_hold #(.MAX_HOLD(8)) dut (
      .i_clock(clk), .i_reset_n(rst_n), .i_req(req), .i_sel_gnt(sel_gnt),
      .i_sel_req_up(sel_req_up), .i_done(done), .o_sel_en(sel_en), .o_gnt(gnt),
      .o_busy(busy), .o_timeout(timeout), .o_err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic [3:0] g, input logic b,
                          input logic s, input logic t, input logic e);
      chk({tag, ".gnt"}, {4'd0, gnt}, {4'd0, g});
      chk({tag, ".busy"}, {7'd0, busy}, {7'd0, b});
      chk({tag, ".sel_en"}, {7'd0, sel_en}, {7'd0, s});
      chk({tag, ".timeout"}, {7'd0, timeout}, {7'd0, t});
      chk({tag, ".err"}, {7'd0, err}, {7'd0, e});
   endtask

   initial begin
      rst_n = 1'b0; req = 4'd0; sel_gnt = 4'd0; sel_req_up = 1'b0; done = 1'b0;
      step();
      step();
      chk_all("reset", 4'd0, 0, 1, 0, 0);
      rst_n = 1'b1;
      // grant from IDLE, non-owner request ignored
      req = 4'b0101; sel_gnt = 4'b0100; sel_req_up = 1'b1;
      step();
      chk_all("grant", 4'b0100, 1, 0, 0, 0);
      req = 4'b1101; sel_gnt = 4'b1000;
      step();
      chk_all("own2", 4'b0100, 1, 0, 0, 0);
      step();
      chk_all("own3", 4'b0100, 1, 0, 0, 0);
      // done releases, pending 1000 granted after the cool-down gap
      done = 1'b1; req = 4'b1000;
      step();
      chk_all("done_cool", 4'd0, 0, 0, 0, 0);
      done = 1'b0;
      step();
      chk_all("done_idle", 4'd0, 0, 1, 0, 0);
      step();
      chk_all("regrant", 4'b1000, 1, 0, 0, 0);
      // hold limit: gnt visible for 8 cycles, then timeout pulse
      sel_req_up = 1'b0; sel_gnt = 4'd0;
      for (int i = 2; i <= 8; i++) begin
         step();
         chk("hold.gnt", {4'd0, gnt}, 8'h08);
         chk("hold.timeout", {7'd0, timeout}, 8'h00);
      end
      step();
      chk_all("tmo", 4'd0, 0, 0, 1, 0);
      step();
      chk_all("tmo_end", 4'd0, 0, 1, 0, 0);
      // done coinciding with the limit: no pulse
      req = 4'b0001; sel_gnt = 4'b0001; sel_req_up = 1'b1;
      step();
      chk_all("grant0", 4'b0001, 1, 0, 0, 0);
      sel_req_up = 1'b0; sel_gnt = 4'd0;
      for (int i = 2; i <= 8; i++) step();
      chk_all("at_limit", 4'b0001, 1, 0, 0, 0);
      done = 1'b1;
      step();
      chk_all("lim_done", 4'd0, 0, 0, 0, 0);
      done = 1'b0;
      step();
      chk_all("lim_done2", 4'd0, 0, 1, 0, 0);
      // owner drops its request
      req = 4'b0010; sel_gnt = 4'b0010; sel_req_up = 1'b1;
      step();
      chk_all("grant1", 4'b0010, 1, 0, 0, 0);
      sel_req_up = 1'b0; sel_gnt = 4'd0;
      step();
      chk_all("grant1b", 4'b0010, 1, 0, 0, 0);
      req = 4'b1001;
      step();
      chk_all("drop_cool", 4'd0, 0, 0, 0, 0);
      step();
      chk_all("drop_idle", 4'd0, 0, 1, 0, 0);
      // multi-hot and zero grants set sticky err
      req = 4'b0110; sel_gnt = 4'b0110; sel_req_up = 1'b1;
      step();
      chk_all("err_multi", 4'd0, 0, 1, 0, 1);
      sel_gnt = 4'd0;
      step();
      chk_all("err_zero", 4'd0, 0, 1, 0, 1);
      sel_req_up = 1'b0; req = 4'd0;
      step();
      chk_all("err_sticky", 4'd0, 0, 1, 0, 1);
      // async reset mid-OWN clears immediately
      req = 4'b0100; sel_gnt = 4'b0100; sel_req_up = 1'b1;
      step();
      chk_all("pre_rst", 4'b0100, 1, 0, 0, 1);
      sel_req_up = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk_all("async_rst", 4'd0, 0, 1, 0, 0);
      step();
      rst_n = 1'b1;
      step();
      chk_all("post_rst", 4'd0, 0, 1, 0, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
